// File: rtl/uart_tx_frame_if.sv
// Host-side word handshake into the UART transmitter.
// The source drives din/din_valid and the transmitter answers with din_ready.
interface uart_tx_frame_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] din;
   logic              din_valid;
   logic              din_ready;

   modport master (output din, output din_valid, input din_ready);
   modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, DATA_W data bits LSB first, optional parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to insert the parity bit (even, or odd with PARITY_ODD=1).
module uart_tx_frame #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1,
   parameter int PARITY_ODD   = 0
) (
   input  logic           clk,
   input  logic           rst,
   uart_tx_frame_if.slave s_if,
   output logic           txd,
   output logic           busy,
   output logic           tx_done
);

   localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W  = 4;

   if (DATA_W < 5 || DATA_W > 9 || CLKS_PER_BIT < 2 || (STOP_BITS != 1 && STOP_BITS != 2) ||
       (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_params
      $error("uart_tx_frame: illegal parameter set");
   end

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t              state_q, state_d;
   logic [BAUD_W-1:0]   baud_q, baud_d;
   logic [BIT_W-1:0]    bit_q, bit_d;
   logic [DATA_W-1:0]   shreg_q, shreg_d;
   logic                txd_q, txd_d;
   logic                busy_q, busy_d;
   logic                tx_done_q, tx_done_d;
`ifdef UART_TX_PARITY_EN
   logic                par_q, par_d;
`endif
   logic                baud_wrap, stop_last, accept;

   assign baud_wrap = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
   assign stop_last = (bit_q == BIT_W'(STOP_BITS - 1));
   // Ready also in the final stop-bit cycle so frames can run back to back.
   assign s_if.din_ready = (state_q == IDLE) || (state_q == STOP && stop_last && baud_wrap);
   assign accept = s_if.din_valid && s_if.din_ready;

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      if (state_q != IDLE) baud_d = baud_wrap ? '0 : baud_q + 1'b1;

      case (state_q)
         START: if (baud_wrap) begin
            state_d = DATA;
            bit_d   = '0;
         end
         DATA: if (baud_wrap) begin
            shreg_d = {1'b0, shreg_q[DATA_W-1:1]};
            if (bit_q == BIT_W'(DATA_W - 1)) begin
               bit_d = '0;
`ifdef UART_TX_PARITY_EN
               state_d = PARITY;
`else
               state_d = STOP;
`endif
            end else begin
               bit_d = bit_q + 1'b1;
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: if (baud_wrap) begin
            state_d = STOP;
            bit_d   = '0;
         end
`endif
         STOP: if (baud_wrap) begin
            if (stop_last) begin
               state_d = IDLE;
               bit_d   = '0;
            end else begin
               bit_d = bit_q + 1'b1;
            end
         end
         default: ;
      endcase

      if (accept) begin
         state_d = START;
         baud_d  = '0;
         bit_d   = '0;
         shreg_d = s_if.din;
`ifdef UART_TX_PARITY_EN
         par_d   = (^s_if.din) ^ PARITY_ODD[0];
`endif
      end

      // Registered outputs are decoded from the next state so they line up with it.
      case (state_d)
         START:   txd_d = 1'b0;
         DATA:    txd_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  txd_d = par_d;
`endif
         default: txd_d = 1'b1;
      endcase
      busy_d    = (state_d != IDLE);
      tx_done_d = (state_d == STOP) && (bit_d == BIT_W'(STOP_BITS - 1)) &&
                  (baud_d == BAUD_W'(CLKS_PER_BIT - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         baud_q    <= '0;
         bit_q     <= '0;
         shreg_q   <= '0;
         txd_q     <= 1'b1;
         busy_q    <= 1'b0;
         tx_done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_q     <= bit_d;
         shreg_q   <= shreg_d;
         txd_q     <= txd_d;
         busy_q    <= busy_d;
         tx_done_q <= tx_done_d;
`ifdef UART_TX_PARITY_EN
         par_q     <= par_d;
`endif
      end
   end

   assign txd     = txd_q;
   assign busy    = busy_q;
   assign tx_done = tx_done_q;

endmodule
